// File: rtl/uart_link_ctrl.sv
// uart_link_ctrl: glue between a UART Receiver/Transmitter pair and host logic.
// RX bytes are synchronised, queued in a small FWFT FIFO and optionally echoed;
// host writes and echo bytes share the Transmitter under round-robin arbitration,
// with a watchdog on the Transmitter's busy acknowledgement.
module uart_link_ctrl #(
  parameter int DEPTH        = 4,
  parameter int BUSY_TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               RX_DATA,
  input  logic                     RX_STATUS,
  input  logic                     TX_STATUS,
  output logic                     TX_EN,
  output logic [7:0]               TX_DATA,
  input  logic                     echo_en,
  input  logic                     host_rd,
  output logic [7:0]               host_rd_data,
  output logic [$clog2(DEPTH):0]   rx_count,
  input  logic                     host_wr,
  input  logic [7:0]               host_wr_data,
  output logic                     host_wr_busy,
  output logic                     rx_overrun,
  output logic                     echo_drop,
  output logic                     tx_timeout,
  input  logic                     err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

  state_t          state, state_n;
  logic            rx_s1, rx_s2, rx_s3;
  logic [7:0]      rx_byte;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            rx_push, rx_pop, fifo_full, push_ok, overrun_set;
  logic            echo_valid, echo_drop_set, echo_load;
  logic [7:0]      echo_byte;
  logic [7:0]      host_byte;
  logic            host_load;
  logic            grant_host, grant_echo, prefer_echo;
  logic            timer_clr, timer_inc, timeout_set;
  logic [TW-1:0]   timer;

  assign rx_push       = rx_s2 & ~rx_s3;
  assign fifo_full     = (rx_count == (AW+1)'(DEPTH));
  assign rx_pop        = host_rd & (rx_count != '0);
  assign push_ok       = rx_push & (~fifo_full | rx_pop);
  assign overrun_set   = rx_push & fifo_full & ~rx_pop;
  assign echo_load     = push_ok & echo_en & ~echo_valid;
  assign echo_drop_set = push_ok & echo_en & echo_valid;
  assign host_load     = host_wr & ~host_wr_busy;
  assign host_rd_data  = mem[rd_ptr];

  // RX_STATUS synchroniser and edge detector; byte captured on the first synced cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1   <= 1'b0;
      rx_s2   <= 1'b0;
      rx_s3   <= 1'b0;
      rx_byte <= '0;
    end else begin
      rx_s1 <= RX_STATUS;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
      if (rx_s1 && !rx_s2) rx_byte <= RX_DATA;
    end
  end

  // RX FIFO storage, pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rx_count <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= rx_byte;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (rx_pop) rd_ptr <= rd_ptr + AW'(1);
      unique case ({push_ok, rx_pop})
        2'b10:   rx_count <= rx_count + 1'b1;
        2'b01:   rx_count <= rx_count - 1'b1;
        default: rx_count <= rx_count;
      endcase
    end
  end

  // Echo and host holding registers; freed at grant, reloadable while a send is in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      echo_valid   <= 1'b0;
      echo_byte    <= '0;
      host_wr_busy <= 1'b0;
      host_byte    <= '0;
    end else begin
      if (grant_echo) echo_valid <= 1'b0;
      if (echo_load) begin
        echo_valid <= 1'b1;
        echo_byte  <= rx_byte;
      end
      if (grant_host) host_wr_busy <= 1'b0;
      if (host_load) begin
        host_wr_busy <= 1'b1;
        host_byte    <= host_wr_data;
      end
    end
  end

  // TX state register, arbitration pointer, busy timer and outgoing byte
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      prefer_echo <= 1'b0;
      timer       <= '0;
      TX_DATA     <= '0;
    end else begin
      state <= state_n;
      // Pointer only moves on contested grants, so an uncontested grant does not
      // cost the other source its turn at the next tie.
      if ((grant_host || grant_echo) && host_wr_busy && echo_valid)
        prefer_echo <= grant_host;
      if (timer_clr)      timer <= '0;
      else if (timer_inc) timer <= timer + 1'b1;
      if (grant_host)      TX_DATA <= host_byte;
      else if (grant_echo) TX_DATA <= echo_byte;
    end
  end

  // TX next-state, grant selection and start pulse
  always_comb begin
    state_n     = state;
    TX_EN       = 1'b0;
    grant_host  = 1'b0;
    grant_echo  = 1'b0;
    timer_clr   = 1'b0;
    timer_inc   = 1'b0;
    timeout_set = 1'b0;
    unique case (state)
      IDLE: begin
        if (TX_STATUS && (host_wr_busy || echo_valid)) begin
          state_n = START;
          if (host_wr_busy && echo_valid) begin
            grant_echo = prefer_echo;
            grant_host = ~prefer_echo;
          end else begin
            grant_host = host_wr_busy;
            grant_echo = ~host_wr_busy;
          end
        end
      end
      START: begin
        TX_EN     = 1'b1;
        timer_clr = 1'b1;
        state_n   = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!TX_STATUS) begin
          state_n = WAIT_DONE;
        end else if (timer == TW'(BUSY_TIMEOUT - 1)) begin
          timeout_set = 1'b1;
          state_n     = IDLE;
        end else begin
          timer_inc = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (TX_STATUS) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Sticky error flags; a new error outranks a simultaneous clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_overrun <= 1'b0;
      echo_drop  <= 1'b0;
      tx_timeout <= 1'b0;
    end else begin
      rx_overrun <= overrun_set   | (rx_overrun & ~err_clr);
      echo_drop  <= echo_drop_set | (echo_drop  & ~err_clr);
      tx_timeout <= timeout_set   | (tx_timeout & ~err_clr);
    end
  end

endmodule
